// File: rtl/pid_pwm_output.sv
// PID output stage: sums P/I/D contributions around mid-scale, saturates to a
// 6-bit control word and drives it onto a glitch-free 64-cycle PWM waveform.
module pid_pwm_output #(
    parameter int W     = 6,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [W-1:0]     p_contrib,
    input  logic [W-1:0]     i_contrib,
    input  logic [W-1:0]     d_contrib,
    output logic [W-1:0]     u_out,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             pwm_out,
    output logic             period_start
);

    localparam int SW = W + 2;

    logic signed [SW-1:0] w_p;
    logic signed [SW-1:0] w_i;
    logic signed [SW-1:0] w_d;
    logic signed [SW-1:0] w_sum;
    logic        [W-1:0]  w_u;
    logic                 w_hi;
    logic                 w_lo;
    logic                 w_wrap;

    logic [W-1:0]     r_u;
    logic             r_sat_hi;
    logic             r_sat_lo;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_duty;

    // 8-bit signed sum spans -64..125, so it cannot overflow.
    assign w_p   = SW'(signed'(p_contrib));
    assign w_i   = SW'(signed'(i_contrib));
    assign w_d   = SW'(signed'(d_contrib));
    assign w_sum = w_p + w_i + w_d + SW'(32);

    assign w_lo = w_sum[SW-1];
    assign w_hi = !w_sum[SW-1] && (w_sum[SW-2:W] != '0);

    always_comb begin
        w_u = w_sum[W-1:0];
        if (w_lo)
            w_u = '0;
        else if (w_hi)
            w_u = '1;
    end

    assign w_wrap = (r_cnt == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_u      <= W'(32);
            r_sat_hi <= 1'b0;
            r_sat_lo <= 1'b0;
            r_cnt    <= '0;
            r_duty   <= '0;
        end else if (ena) begin
            r_u      <= w_u;
            r_sat_hi <= w_hi;
            r_sat_lo <= w_lo;
            r_cnt    <= r_cnt + 1'b1;
            // Duty is only adopted at the period boundary, using the word held before this edge.
            if (w_wrap)
                r_duty <= r_u;
        end
    end

    assign u_out        = r_u;
    assign sat_hi       = r_sat_hi;
    assign sat_lo       = r_sat_lo;
    assign pwm_out      = (r_cnt < CNT_W'(r_duty));
    assign period_start = (r_cnt == '0);

endmodule

// File: tb/tb_pid_pwm_output.sv
// Bench for pid_pwm_output: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a period-level model.
module tb_pid_pwm_output;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [5:0] p_contrib;
    logic [5:0] i_contrib;
    logic [5:0] d_contrib;
    logic [5:0] u_out;
    logic       sat_hi;
    logic       sat_lo;
    logic       pwm_out;
    logic       period_start;

    int n_checks = 0;
    int n_errors = 0;

    pid_pwm_output #(.W(6), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .p_contrib    (p_contrib),
        .i_contrib    (i_contrib),
        .d_contrib    (d_contrib),
        .u_out        (u_out),
        .sat_hi       (sat_hi),
        .sat_lo       (sat_lo),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    // Model: phase = enabled cycles since reset mod 64; duty = word captured at last wrap.
    int  m_phase;
    int  m_duty;
    int  m_u;
    bit  m_hi;
    bit  m_lo;
    bit  m_valid = 1'b0;

    function automatic int raw_sum(input logic [5:0] p, input logic [5:0] i, input logic [5:0] d);
        int a, b, c;
        a = $signed(p);
        b = $signed(i);
        c = $signed(d);
        return a + b + c + 32;
    endfunction

    function automatic int clamp63(input int s);
        if (s < 0)  return 0;
        if (s > 63) return 63;
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_duty  <= 0;
            m_u     <= 32;
            m_hi    <= 1'b0;
            m_lo    <= 1'b0;
            m_valid <= 1'b1;
        end else if (ena) begin
            m_u     <= clamp63(raw_sum(p_contrib, i_contrib, d_contrib));
            m_hi    <= raw_sum(p_contrib, i_contrib, d_contrib) > 63;
            m_lo    <= raw_sum(p_contrib, i_contrib, d_contrib) < 0;
            m_phase <= (m_phase + 1) % 64;
            if (m_phase == 63)
                m_duty <= m_u;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_u_out", int'(u_out), m_u);
            chk("model_sat_hi", int'(sat_hi), int'(m_hi));
            chk("model_sat_lo", int'(sat_lo), int'(m_lo));
            chk("model_pwm", int'(pwm_out), int'(m_phase < m_duty));
            chk("model_period_start", int'(period_start), int'(m_phase == 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int p, input int i, input int d);
        p_contrib = 6'(p);
        i_contrib = 6'(i);
        d_contrib = 6'(d);
    endtask

    task automatic rand_in();
        p_contrib = 6'($urandom);
        i_contrib = 6'($urandom);
        d_contrib = 6'($urandom);
    endtask

    task automatic goto_cnt0();
        int n;
        n = 0;
        step();
        while (!period_start && n < 70) begin
            step();
            n++;
        end
        if (!period_start)
            chk("goto_cnt0_timeout", 0, 1);
    endtask

    // Samples one full period starting at cnt=0; optionally changes inputs at sample chg_at.
    task automatic count_period(input int chg_at, input int np, input int ni, input int nd,
                                output int highs);
        highs = 0;
        for (int k = 0; k < 64; k++) begin
            if (pwm_out) highs++;
            if (k == chg_at) set_in(np, ni, nd);
            step();
        end
    endtask

    int hi_cnt;
    logic [5:0] held_u;

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        rand_in();
        step();
        rand_in();
        step();
        chk("reset_u_out", int'(u_out), 32);
        chk("reset_sat_hi", int'(sat_hi), 0);
        chk("reset_sat_lo", int'(sat_lo), 0);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_period_start", int'(period_start), 1);

        rst_n = 1'b1;
        set_in(0, 0, 0);
        count_period(-1, 0, 0, 0, hi_cnt);
        chk("first_period_highs", hi_cnt, 0);
        chk("second_period_first_high", int'(pwm_out), 1);
        count_period(-1, 0, 0, 0, hi_cnt);
        chk("second_period_highs", hi_cnt, 32);

        // Positive saturation
        set_in(31, 31, 31);
        step();
        chk("pos_u_out", int'(u_out), 63);
        chk("pos_sat_hi", int'(sat_hi), 1);
        chk("pos_sat_lo", int'(sat_lo), 0);
        goto_cnt0();
        count_period(-1, 31, 31, 31, hi_cnt);
        chk("pos_period_highs", hi_cnt, 63);

        // Negative saturation, then an unsaturated value
        set_in(-32, -32, -32);
        step();
        chk("neg_u_out", int'(u_out), 0);
        chk("neg_sat_lo", int'(sat_lo), 1);
        chk("neg_sat_hi", int'(sat_hi), 0);
        goto_cnt0();
        count_period(-1, -32, -32, -32, hi_cnt);
        chk("neg_period_highs", hi_cnt, 0);
        set_in(5, -3, -10);
        step();
        chk("mid_u_out", int'(u_out), 24);
        chk("mid_sat_hi", int'(sat_hi), 0);
        chk("mid_sat_lo", int'(sat_lo), 0);

        // Mid-period change to 10 while duty 32 is active
        set_in(0, 0, 0);
        goto_cnt0();
        count_period(20, -10, -6, -6, hi_cnt);
        chk("chg_mid_cur_highs", hi_cnt, 32);
        count_period(-1, 0, 0, 0, hi_cnt);
        chk("chg_mid_next_highs", hi_cnt, 10);

        // Change to 50 landing on the wrap edge: takes one extra period
        count_period(63, 6, 6, 6, hi_cnt);
        chk("chg_wrap_cur_highs", hi_cnt, 10);
        count_period(-1, 0, 0, 0, hi_cnt);
        chk("chg_wrap_next_highs", hi_cnt, 10);
        count_period(-1, 0, 0, 0, hi_cnt);
        chk("chg_wrap_late_highs", hi_cnt, 50);

        // ena gating at cnt=15 with duty 50 active
        hi_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            if (pwm_out) hi_cnt++;
            if (k == 15) begin
                held_u = u_out;
                ena = 1'b0;
                for (int j = 0; j < 7; j++) begin
                    rand_in();
                    step();
                    chk("gate_u_held", int'(u_out), int'(held_u));
                    chk("gate_pwm_held", int'(pwm_out), 1);
                    chk("gate_ps_held", int'(period_start), 0);
                end
                ena = 1'b1;
                set_in(6, 6, 6);
            end
            step();
            if (k == 15) chk("gate_resume_u", int'(u_out), 50);
        end
        chk("gate_period_highs", hi_cnt, 50);
        chk("gate_period_wrapped", int'(period_start), 1);

        // Reset mid-period at cnt=40, duty 50
        for (int k = 0; k < 40; k++) step();
        chk("pre_rst_pwm", int'(pwm_out), 1);
        rst_n = 1'b0;
        rand_in();
        step();
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_ps", int'(period_start), 1);
        chk("mid_rst_u", int'(u_out), 32);
        rst_n = 1'b1;
        set_in(0, 0, 0);
        count_period(-1, 0, 0, 0, hi_cnt);
        chk("post_rst_first_highs", hi_cnt, 0);
        count_period(-1, 0, 0, 0, hi_cnt);
        chk("post_rst_second_highs", hi_cnt, 32);

        // Randomized phase: model compare does the checking
        for (int k = 0; k < 4000; k++) begin
            rand_in();
            ena   = ($urandom_range(0, 9) < 8);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
